seq_alu: RTL and testbench
==========================

// Module: seq_alu
// PURPOSE
//   Parametrised multi-cycle ALU for the single-cycle CPU datapath's execute stage.
//   Keeps the 4-bit op encoding of the 16-bit combinational ALU, adds a start/busy/done
//   handshake, iterative MUL (shift-add) and DIV/MOD (restoring), a high product word,
//   and status flags (zero, carry, overflow, div-by-zero, illegal op).
// PARAMETERS
//   WIDTH   16  operand/result width; >= 4, power of 2
//   CNT_W   $clog2(WIDTH)+1  iteration counter width (derived, not overridden)
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-high reset
//   start    in   1      request; operands and op sampled when start=1 and busy=0
//   alu_op   in   4      operation code (table below)
//   in1      in   WIDTH  operand A (unsigned unless stated)
//   in2      in   WIDTH  operand B / shift amount
//   busy     out  1      1 while an operation is in flight
//   done     out  1      one-cycle pulse: Z, Z_hi and flags valid
//   Z        out  WIDTH  result, held until next done
//   Z_hi     out  WIDTH  MUL: upper product word; all other ops 0
//   flag_z   out  1      Z == 0
//   flag_c   out  1      ADD carry-out; SUB borrow (in1 < in2 unsigned); else 0
//   flag_v   out  1      ADD/SUB signed overflow; else 0
//   flag_dz  out  1      DIV/MOD with in2 == 0
//   flag_ill out  1      alu_op in 12..15
// BEHAVIOUR
//   Ops: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 SHL, 6 SHR logical, 7 SRA (in1 >>> in2),
//        8 CLR (Z=0), 9 AND, 10 OR, 11 NOT (~in1), 12-15 illegal -> Z=0, flag_ill=1.
//   Reset: busy=0, done=0, Z=0, Z_hi=0, all flags 0, FSM=IDLE, internal regs 0.
//   FSM: IDLE --start & op in {2,3,4}--> ITER; IDLE --start & other op--> IDLE (done=1).
//        ITER --counter==0--> IDLE (done=1). No other transitions.
//   Latency (start sampled at edge E0): single-cycle ops register Z/flags/done at E0,
//     done high for the cycle after E0, busy never rises. MUL/DIV/MOD: busy=1 from E0;
//     one iteration per edge E1..E_WIDTH; result, done=1, busy=0 registered at E_WIDTH+1.
//   Operands latched at E0; in1/in2/alu_op changes during ITER have no effect.
//   start while busy=1: ignored, no queueing, no error.
//   done is a single-cycle pulse; Z, Z_hi and flags hold until the next done.
//   MUL: unsigned 2*WIDTH product; low half -> Z, high half -> Z_hi.
//   DIV/MOD: unsigned restoring division. in2==0: skip iteration (single-cycle path),
//     DIV Z={WIDTH{1}}, MOD Z=in1, flag_dz=1.
//   Shifts: amount = in2 as unsigned; amount >= WIDTH gives SHL/SHR 0, SRA all sign bits.
//   flag_z always computed from the final Z (including CLR and illegal ops).
//   Reset mid-operation aborts the operation; no done is produced for it.
// TESTING (WIDTH=16)
//   ADD 0x7FFF+0x0001 -> done at E0, Z=0x8000, flag_v=1, flag_c=0; 0xFFFF+1 -> Z=0, c=1, z=1
//   MUL 0x1234*0x5678 -> busy 17 cycles, Z=0x0060, Z_hi=0x0626, done pulses exactly once
//   DIV 100/7 -> Z=14; MOD 100%7 -> Z=2; DIV 5/0 -> Z=0xFFFF, flag_dz=1, single-cycle
//   SRA 0x8000>>>20 -> Z=0xFFFF; SHL 0x0001<<16 -> Z=0, flag_z=1; op 13 -> flag_ill=1
//   start during MUL with ADD operands -> ignored; MUL result unchanged, one done only
//   rst asserted at iteration 8 of DIV -> busy/done/Z/flags 0 immediately, no done later

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU for the execute stage.
//   Single-cycle ops (ADD/SUB/shifts/logic/CLR/illegal, DIV/MOD by zero) finish at
//   the edge that samples start. MUL (shift-add) and DIV/MOD (restoring) iterate
//   once per clock for WIDTH clocks, then take one more clock to publish the result.
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request; alu_op/in1/in2 sampled when start=1 and busy=0
//   alu_op          4-bit operation code (12..15 illegal)
//   in1, in2        operands (in2 doubles as shift amount)
//   busy            high while MUL/DIV/MOD is iterating
//   done            one-cycle pulse when Z/Z_hi/flags are updated
//   Z, Z_hi         result and MUL upper product word (0 for other ops)
//   flag_z/c/v/dz/ill  zero, carry/borrow, signed overflow, div-by-zero, illegal op
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z,
    output logic [WIDTH-1:0] Z_hi,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             flag_dz,
    output logic             flag_ill
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int SH_W  = $clog2(WIDTH);

    typedef enum logic {IDLE, ITER} state_t;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
        OP_MOD = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_SRA = 4'd7,
        OP_CLR = 4'd8, OP_AND = 4'd9, OP_OR  = 4'd10, OP_NOT = 4'd11
    } op_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    op_t              op_r, op_n;
    logic [WIDTH-1:0] d_r, d_n;       // multiplicand or divisor
    logic [WIDTH-1:0] rem_r, rem_n;   // MUL: high partial product; DIV: remainder
    logic [WIDTH-1:0] q_r, q_n;       // MUL: multiplier/low product; DIV: quotient

    logic [WIDTH:0]   msum, dshift, ddiff;
    logic [SH_W-1:0]  sh_amt;
    logic             shift_big;

    logic             fin;
    logic [WIDTH-1:0] res, res_hi;
    logic             res_c, res_v, res_dz, res_ill;

    assign busy = (state == ITER);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_r;
        d_n     = d_r;
        rem_n   = rem_r;
        q_n     = q_r;
        fin     = 1'b0;
        res     = '0;
        res_hi  = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_dz  = 1'b0;
        res_ill = 1'b0;

        // One MUL step adds the multiplicand when the multiplier LSB is set, then
        // the {rem,q} pair shifts right so the product accumulates across both words.
        msum   = {1'b0, rem_r} + (q_r[0] ? {1'b0, d_r} : '0);
        // One restoring DIV step brings the next dividend bit into the remainder.
        dshift = {rem_r, q_r[WIDTH-1]};
        ddiff  = dshift - {1'b0, d_r};

        sh_amt    = in2[SH_W-1:0];
        shift_big = |(in2 >> SH_W);

        case (state)
            IDLE: begin
                if (start) begin
                    fin = 1'b1;
                    case (alu_op)
                        OP_ADD: begin
                            {res_c, res} = {1'b0, in1} + {1'b0, in2};
                            res_v = (in1[WIDTH-1] == in2[WIDTH-1]) && (res[WIDTH-1] != in1[WIDTH-1]);
                        end
                        OP_SUB: begin
                            res   = in1 - in2;
                            res_c = (in1 < in2);
                            res_v = (in1[WIDTH-1] != in2[WIDTH-1]) && (res[WIDTH-1] != in1[WIDTH-1]);
                        end
                        OP_MUL: begin
                            fin     = 1'b0;
                            state_n = ITER;
                            cnt_n   = CNT_W'(WIDTH);
                            op_n    = OP_MUL;
                            d_n     = in1;
                            q_n     = in2;
                            rem_n   = '0;
                        end
                        OP_DIV, OP_MOD: begin
                            if (in2 == '0) begin
                                res_dz = 1'b1;
                                res    = (alu_op == OP_DIV) ? '1 : in1;
                            end else begin
                                fin     = 1'b0;
                                state_n = ITER;
                                cnt_n   = CNT_W'(WIDTH);
                                op_n    = (alu_op == OP_DIV) ? OP_DIV : OP_MOD;
                                d_n     = in2;
                                q_n     = in1;
                                rem_n   = '0;
                            end
                        end
                        OP_SHL: res = shift_big ? '0 : (in1 << sh_amt);
                        OP_SHR: res = shift_big ? '0 : (in1 >> sh_amt);
                        OP_SRA: begin
                            res = $unsigned($signed(in1) >>> sh_amt);
                            if (shift_big) res = {WIDTH{in1[WIDTH-1]}};
                        end
                        OP_CLR: res = '0;
                        OP_AND: res = in1 & in2;
                        OP_OR:  res = in1 | in2;
                        OP_NOT: res = ~in1;
                        default: res_ill = 1'b1;
                    endcase
                end
            end
            ITER: begin
                if (cnt == '0) begin
                    fin     = 1'b1;
                    state_n = IDLE;
                    case (op_r)
                        OP_MUL: begin
                            res    = q_r;
                            res_hi = rem_r;
                        end
                        OP_DIV:  res = q_r;
                        default: res = rem_r;
                    endcase
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                    if (op_r == OP_MUL) begin
                        rem_n = msum[WIDTH:1];
                        q_n   = {msum[0], q_r[WIDTH-1:1]};
                    end else if (dshift >= {1'b0, d_r}) begin
                        rem_n = ddiff[WIDTH-1:0];
                        q_n   = {q_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_n = dshift[WIDTH-1:0];
                        q_n   = {q_r[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_r     <= OP_ADD;
            d_r      <= '0;
            rem_r    <= '0;
            q_r      <= '0;
            done     <= 1'b0;
            Z        <= '0;
            Z_hi     <= '0;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
            flag_dz  <= 1'b0;
            flag_ill <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_r  <= op_n;
            d_r   <= d_n;
            rem_r <= rem_n;
            q_r   <= q_n;
            done  <= fin;
            if (fin) begin
                Z        <= res;
                Z_hi     <= res_hi;
                flag_z   <= (res == '0);
                flag_c   <= res_c;
                flag_v   <= res_v;
                flag_dz  <= res_dz;
                flag_ill <= res_ill;
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH=16).
module tb_seq_alu;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                           OP_MOD = 4'd4, OP_SHL = 4'd5, OP_SHR = 4'd6, OP_SRA = 4'd7,
                           OP_CLR = 4'd8, OP_AND = 4'd9, OP_OR = 4'd10, OP_NOT = 4'd11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        busy, done, flag_z, flag_c, flag_v, flag_dz, flag_ill;
    logic [15:0] Z, Z_hi;
    logic [6:0]  st;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .Z(Z), .Z_hi(Z_hi), .flag_z(flag_z), .flag_c(flag_c),
        .flag_v(flag_v), .flag_dz(flag_dz), .flag_ill(flag_ill)
    );

    always #5 clk = ~clk;

    // status vector: done, busy, z, c, v, dz, ill
    assign st = {done, busy, flag_z, flag_c, flag_v, flag_dz, flag_ill};

    task automatic start_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        alu_op = op; in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Called one time unit after E0; returns edges until done and busy samples seen.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        if (busy) bcnt++;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (st !== 7'b0000000) begin errors++; $display("FAIL reset_status: got %b expected %b", st, 7'b0000000); end
        checks++; if (Z !== 16'h0000) begin errors++; $display("FAIL reset_z: got %h expected %h", Z, 16'h0000); end
        checks++; if (Z_hi !== 16'h0000) begin errors++; $display("FAIL reset_zhi: got %h expected %h", Z_hi, 16'h0000); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_add_sub;
        start_op(OP_ADD, 16'h7FFF, 16'h0001);
        checks++; if (Z !== 16'h8000) begin errors++; $display("FAIL add_ovf_z: got %h expected %h", Z, 16'h8000); end
        checks++; if (st !== 7'b1000100) begin errors++; $display("FAIL add_ovf_status: got %b expected %b", st, 7'b1000100); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0 || Z !== 16'h8000) begin errors++; $display("FAIL add_hold: got done=%b Z=%h expected done=0 Z=8000", done, Z); end
        start_op(OP_ADD, 16'hFFFF, 16'h0001);
        checks++; if (Z !== 16'h0000) begin errors++; $display("FAIL add_carry_z: got %h expected %h", Z, 16'h0000); end
        checks++; if (st !== 7'b1011000) begin errors++; $display("FAIL add_carry_status: got %b expected %b", st, 7'b1011000); end
        start_op(OP_SUB, 16'h0003, 16'h0005);
        checks++; if (Z !== 16'hFFFE) begin errors++; $display("FAIL sub_borrow_z: got %h expected %h", Z, 16'hFFFE); end
        checks++; if (st !== 7'b1001000) begin errors++; $display("FAIL sub_borrow_status: got %b expected %b", st, 7'b1001000); end
        start_op(OP_SUB, 16'h8000, 16'h0001);
        checks++; if (Z !== 16'h7FFF) begin errors++; $display("FAIL sub_ovf_z: got %h expected %h", Z, 16'h7FFF); end
        checks++; if (st !== 7'b1000100) begin errors++; $display("FAIL sub_ovf_status: got %b expected %b", st, 7'b1000100); end
    endtask

    task automatic test_mul;
        int lat, bcnt, extra;
        start_op(OP_MUL, 16'h1234, 16'h5678);
        checks++; if ({done, busy} !== 2'b01) begin errors++; $display("FAIL mul_e0: got done,busy=%b expected 01", {done, busy}); end
        wait_done(lat, bcnt);
        checks++; if (lat !== 17) begin errors++; $display("FAIL mul_latency: got %0d expected 17", lat); end
        checks++; if (bcnt !== 17) begin errors++; $display("FAIL mul_busy_cycles: got %0d expected 17", bcnt); end
        checks++; if (Z !== 16'h0060) begin errors++; $display("FAIL mul_lo: got %h expected %h", Z, 16'h0060); end
        checks++; if (Z_hi !== 16'h0626) begin errors++; $display("FAIL mul_hi: got %h expected %h", Z_hi, 16'h0626); end
        checks++; if (st !== 7'b1000000) begin errors++; $display("FAIL mul_status: got %b expected %b", st, 7'b1000000); end
        extra = 0;
        repeat (5) begin @(posedge clk); #1; if (done) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL mul_single_done: got %0d extra pulses expected 0", extra); end
        start_op(OP_ADD, 16'h0001, 16'h0002);
        checks++; if (Z !== 16'h0003 || Z_hi !== 16'h0000) begin errors++; $display("FAIL zhi_cleared: got Z=%h Z_hi=%h expected 0003 0000", Z, Z_hi); end
    endtask

    task automatic test_div_mod;
        int lat, bcnt;
        start_op(OP_DIV, 16'd100, 16'd7);
        wait_done(lat, bcnt);
        checks++; if (lat !== 17) begin errors++; $display("FAIL div_latency: got %0d expected 17", lat); end
        checks++; if (Z !== 16'd14) begin errors++; $display("FAIL div_z: got %0d expected 14", Z); end
        checks++; if (st !== 7'b1000000 || Z_hi !== 16'h0) begin errors++; $display("FAIL div_status: got %b hi=%h expected %b hi=0000", st, Z_hi, 7'b1000000); end
        start_op(OP_MOD, 16'd100, 16'd7);
        wait_done(lat, bcnt);
        checks++; if (Z !== 16'd2) begin errors++; $display("FAIL mod_z: got %0d expected 2", Z); end
        start_op(OP_DIV, 16'd5, 16'd0);
        checks++; if (Z !== 16'hFFFF) begin errors++; $display("FAIL div0_z: got %h expected %h", Z, 16'hFFFF); end
        checks++; if (st !== 7'b1000010) begin errors++; $display("FAIL div0_status: got %b expected %b", st, 7'b1000010); end
        start_op(OP_MOD, 16'd5, 16'd0);
        checks++; if (Z !== 16'd5 || st !== 7'b1000010) begin errors++; $display("FAIL mod0: got Z=%h st=%b expected 0005 1000010", Z, st); end
    endtask

    task automatic test_shift;
        start_op(OP_SRA, 16'h8000, 16'd20);
        checks++; if (Z !== 16'hFFFF || st !== 7'b1000000) begin errors++; $display("FAIL sra_big: got Z=%h st=%b expected ffff 1000000", Z, st); end
        start_op(OP_SHL, 16'h0001, 16'd16);
        checks++; if (Z !== 16'h0000 || st !== 7'b1010000) begin errors++; $display("FAIL shl_big: got Z=%h st=%b expected 0000 1010000", Z, st); end
        start_op(OP_SHL, 16'h0001, 16'd15);
        checks++; if (Z !== 16'h8000) begin errors++; $display("FAIL shl_15: got %h expected %h", Z, 16'h8000); end
        start_op(OP_SHR, 16'h8000, 16'd4);
        checks++; if (Z !== 16'h0800) begin errors++; $display("FAIL shr_4: got %h expected %h", Z, 16'h0800); end
        start_op(OP_SRA, 16'h8000, 16'd4);
        checks++; if (Z !== 16'hF800) begin errors++; $display("FAIL sra_4: got %h expected %h", Z, 16'hF800); end
        start_op(OP_SHR, 16'h8000, 16'd16);
        checks++; if (Z !== 16'h0000) begin errors++; $display("FAIL shr_big: got %h expected %h", Z, 16'h0000); end
    endtask

    task automatic test_logic_ill;
        start_op(OP_AND, 16'hF0F0, 16'hFF00);
        checks++; if (Z !== 16'hF000) begin errors++; $display("FAIL and: got %h expected %h", Z, 16'hF000); end
        start_op(OP_OR, 16'hF0F0, 16'hFF00);
        checks++; if (Z !== 16'hFFF0) begin errors++; $display("FAIL or: got %h expected %h", Z, 16'hFFF0); end
        start_op(OP_NOT, 16'h00FF, 16'h1234);
        checks++; if (Z !== 16'hFF00) begin errors++; $display("FAIL not: got %h expected %h", Z, 16'hFF00); end
        start_op(OP_CLR, 16'h1234, 16'h5678);
        checks++; if (Z !== 16'h0000 || st !== 7'b1010000) begin errors++; $display("FAIL clr: got Z=%h st=%b expected 0000 1010000", Z, st); end
        start_op(4'd13, 16'h1234, 16'h5678);
        checks++; if (Z !== 16'h0000 || st !== 7'b1010001) begin errors++; $display("FAIL illegal: got Z=%h st=%b expected 0000 1010001", Z, st); end
        start_op(OP_ADD, 16'h0002, 16'h0002);
        checks++; if (Z !== 16'h0004 || st !== 7'b1000000) begin errors++; $display("FAIL ill_cleared: got Z=%h st=%b expected 0004 1000000", Z, st); end
    endtask

    task automatic test_back_to_back;
        int k, done_k, bcnt, extra;
        start_op(OP_ADD, 16'h0010, 16'h0020);
        start_op(OP_SUB, 16'h0010, 16'h0001);
        checks++; if (Z !== 16'h000F || done !== 1'b1) begin errors++; $display("FAIL b2b_single: got Z=%h done=%b expected 000f 1", Z, done); end
        // MUL with a competing ADD request and operand changes while iterating
        start_op(OP_MUL, 16'h1234, 16'h5678);
        bcnt = busy ? 1 : 0;
        done_k = -1;
        for (k = 1; k <= 40 && done_k < 0; k++) begin
            @(negedge clk);
            if (k >= 2 && k <= 5) begin
                start = 1'b1; alu_op = OP_ADD; in1 = 16'h0001; in2 = 16'h0001;
            end else begin
                start = 1'b0; in1 = 16'hAAAA; in2 = 16'h5555;
            end
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) done_k = k;
        end
        start = 1'b0;
        checks++; if (done_k !== 17) begin errors++; $display("FAIL busy_ignore_latency: got %0d expected 17", done_k); end
        checks++; if (bcnt !== 17) begin errors++; $display("FAIL busy_ignore_cycles: got %0d expected 17", bcnt); end
        checks++; if (Z !== 16'h0060 || Z_hi !== 16'h0626) begin errors++; $display("FAIL busy_ignore_result: got %h_%h expected 0626_0060", Z_hi, Z); end
        extra = 0;
        repeat (20) begin @(posedge clk); #1; if (done) extra++; end
        checks++; if (extra !== 0) begin errors++; $display("FAIL busy_ignore_no_queue: got %0d extra pulses expected 0", extra); end
    endtask

    task automatic test_reset_mid;
        int dn, bz;
        start_op(OP_ADD, 16'h0001, 16'h0001);
        start_op(OP_DIV, 16'd100, 16'd7);
        repeat (8) @(posedge clk);
        #1;
        checks++; if (Z !== 16'h0002 || busy !== 1'b1) begin errors++; $display("FAIL div_hold_mid: got Z=%h busy=%b expected 0002 1", Z, busy); end
        #2; rst = 1'b1; #1;
        checks++; if (st !== 7'b0000000 || Z !== 16'h0 || Z_hi !== 16'h0) begin errors++; $display("FAIL rst_mid: got st=%b Z=%h hi=%h expected all 0", st, Z, Z_hi); end
        @(negedge clk); rst = 1'b0;
        dn = 0; bz = 0;
        repeat (30) begin @(posedge clk); #1; if (done) dn++; if (busy) bz++; end
        checks++; if (dn !== 0 || bz !== 0) begin errors++; $display("FAIL rst_no_done: got done=%0d busy=%0d expected 0 0", dn, bz); end
        start_op(OP_ADD, 16'h0002, 16'h0003);
        checks++; if (Z !== 16'h0005 || st !== 7'b1000000) begin errors++; $display("FAIL post_rst_add: got Z=%h st=%b expected 0005 1000000", Z, st); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_mul();
        test_div_mod();
        test_shift();
        test_logic_ill();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
